// File: rtl/stack_pkg.sv
// Shared types and size helpers for the LIFO/FIFO operand buffer.
package stack_pkg;

    typedef enum logic {MODE_LIFO = 1'b0, MODE_FIFO = 1'b1} stk_mode_t;

    localparam int unsigned DEF_DATA_SIZE  = 8;
    localparam int unsigned DEF_STACK_SIZE = 4;

    function automatic int unsigned depth_of(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

    // One extra bit so the count can represent a completely full buffer.
    function automatic int unsigned cnt_w_of(input int unsigned addr_w);
        return addr_w + 32'd1;
    endfunction

endpackage

// File: rtl/stack_ram.sv
// DEPTH x DATA_SIZE register file: one synchronous write port, one asynchronous read port.
module stack_ram #(
    parameter int unsigned DATA_SIZE = 8,
    parameter int unsigned ADDR_W    = 4
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [ADDR_W-1:0]    waddr_i,
    input  logic [DATA_SIZE-1:0] wdata_i,
    input  logic [ADDR_W-1:0]    raddr_i,
    output logic [DATA_SIZE-1:0] rdata_o
);

    localparam int unsigned DEPTH = 32'd1 << ADDR_W;

    logic [DATA_SIZE-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/stack_queue_buf.sv
// Run-time selectable LIFO/FIFO buffer with registered pop data, occupancy flags and sticky errors.
module stack_queue_buf
    import stack_pkg::*;
#(
    parameter int unsigned DATA_SIZE  = DEF_DATA_SIZE,
    parameter int unsigned STACK_SIZE = DEF_STACK_SIZE,
    parameter int unsigned AF_LEVEL   = depth_of(STACK_SIZE) - 32'd2,
    parameter int unsigned AE_LEVEL   = 32'd1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  MODE,
    input  logic                  W,
    input  logic                  R,
    input  logic                  FLUSH,
    input  logic                  CLR_ERR,
    input  logic [DATA_SIZE-1:0]  DATA_WR,
    output logic [DATA_SIZE-1:0]  DATA_RD,
    output logic                  RD_VALID,
    output logic [STACK_SIZE:0]   COUNT,
    output logic                  stack_full,
    output logic                  stack_empty,
    output logic                  ALMOST_FULL,
    output logic                  ALMOST_EMPTY,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW
);

    localparam int unsigned DEPTH  = depth_of(STACK_SIZE);
    localparam int unsigned ADDR_W = STACK_SIZE;
    localparam int unsigned CNT_W  = cnt_w_of(STACK_SIZE);

    logic [CNT_W-1:0]     count_q, count_d;
    logic [ADDR_W-1:0]    wptr_q, wptr_d;
    logic [ADDR_W-1:0]    rptr_q, rptr_d;
    stk_mode_t            mode_q, mode_d;
    logic [DATA_SIZE-1:0] data_rd_q, data_rd_d;
    logic                 rd_valid_q, rd_valid_d;
    logic                 ovf_q, ovf_d;
    logic                 unf_q, unf_d;

    logic                 empty, full;
    logic                 pop_acc, push_acc;
    logic [ADDR_W-1:0]    lifo_top;
    logic [ADDR_W-1:0]    ram_waddr, ram_raddr;
    logic [DATA_SIZE-1:0] ram_rdata;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign lifo_top = ADDR_W'(count_q - CNT_W'(1));

    // FLUSH masks both requests so they neither move data nor raise errors.
    assign pop_acc  = R && !empty && !FLUSH;
    assign push_acc = W && (!full || pop_acc) && !FLUSH;

    // A LIFO push paired with a pop overwrites the slot being popped.
    always_comb begin
        ram_raddr = lifo_top;
        ram_waddr = pop_acc ? lifo_top : ADDR_W'(count_q);
        if (mode_q == MODE_FIFO) begin
            ram_raddr = rptr_q;
            ram_waddr = wptr_q;
        end
    end

    stack_ram #(
        .DATA_SIZE (DATA_SIZE),
        .ADDR_W    (ADDR_W)
    ) u_ram (
        .clk_i   (CLK),
        .we_i    (push_acc),
        .waddr_i (ram_waddr),
        .wdata_i (DATA_WR),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        count_d    = count_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        mode_d     = mode_q;
        data_rd_d  = data_rd_q;
        rd_valid_d = 1'b0;
        ovf_d      = (ovf_q && !CLR_ERR) || (W && !push_acc && !FLUSH);
        unf_d      = (unf_q && !CLR_ERR) || (R && !pop_acc && !FLUSH);

        if (empty && !push_acc) begin
            mode_d = stk_mode_t'(MODE);
        end

        if (FLUSH) begin
            count_d = '0;
            wptr_d  = '0;
            rptr_d  = '0;
        end else begin
            if (pop_acc) begin
                data_rd_d  = ram_rdata;
                rd_valid_d = 1'b1;
            end
            if (push_acc && !pop_acc) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop_acc && !push_acc) begin
                count_d = count_q - CNT_W'(1);
            end
            if (mode_q == MODE_FIFO) begin
                if (push_acc) wptr_d = wptr_q + ADDR_W'(1);
                if (pop_acc)  rptr_d = rptr_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            count_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            mode_q     <= MODE_LIFO;
            data_rd_q  <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            count_q    <= count_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            mode_q     <= mode_d;
            data_rd_q  <= data_rd_d;
            rd_valid_q <= rd_valid_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    assign COUNT        = count_q;
    assign DATA_RD      = data_rd_q;
    assign RD_VALID     = rd_valid_q;
    assign OVERFLOW     = ovf_q;
    assign UNDERFLOW    = unf_q;
    assign stack_full   = full;
    assign stack_empty  = empty;
    assign ALMOST_FULL  = (count_q >= CNT_W'(AF_LEVEL));
    assign ALMOST_EMPTY = (count_q <= CNT_W'(AE_LEVEL));

endmodule

// File: tb/tb_stack_queue_buf.sv
// Directed and randomized checks of stack_queue_buf against a queue-based reference model.
module tb_stack_queue_buf;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       MODE = 1'b0;
    logic       W = 1'b0;
    logic       R = 1'b0;
    logic       FLUSH = 1'b0;
    logic       CLR_ERR = 1'b0;
    logic [7:0] DATA_WR = 8'h00;
    logic [7:0] DATA_RD;
    logic       RD_VALID;
    logic [2:0] COUNT;
    logic       stack_full, stack_empty, ALMOST_FULL, ALMOST_EMPTY, OVERFLOW, UNDERFLOW;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [7:0] mq[$];
    logic       m_fifo = 1'b0;
    logic [7:0] m_rd = 8'h00;
    logic       m_valid = 1'b0;
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;

    stack_queue_buf #(
        .DATA_SIZE  (8),
        .STACK_SIZE (2),
        .AF_LEVEL   (3),
        .AE_LEVEL   (1)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .MODE         (MODE),
        .W            (W),
        .R            (R),
        .FLUSH        (FLUSH),
        .CLR_ERR      (CLR_ERR),
        .DATA_WR      (DATA_WR),
        .DATA_RD      (DATA_RD),
        .RD_VALID     (RD_VALID),
        .COUNT        (COUNT),
        .stack_full   (stack_full),
        .stack_empty  (stack_empty),
        .ALMOST_FULL  (ALMOST_FULL),
        .ALMOST_EMPTY (ALMOST_EMPTY),
        .OVERFLOW     (OVERFLOW),
        .UNDERFLOW    (UNDERFLOW)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply the rules to the model using the inputs currently driven.
    task automatic model_update();
        int  sz;
        bit  pop_ok, push_ok;
        sz = mq.size();
        if (RST) begin
            mq.delete();
            m_fifo = 1'b0; m_rd = 8'h00; m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
            return;
        end
        pop_ok  = !FLUSH && R && (sz > 0);
        push_ok = !FLUSH && W && ((sz < 4) || pop_ok);
        m_ovf = (m_ovf && !CLR_ERR) || (!FLUSH && W && !push_ok);
        m_unf = (m_unf && !CLR_ERR) || (!FLUSH && R && !pop_ok);
        m_valid = pop_ok;
        if (FLUSH) begin
            mq.delete();
        end else begin
            if (pop_ok) m_rd = m_fifo ? mq.pop_front() : mq.pop_back();
            if (push_ok) mq.push_back(DATA_WR);
        end
        if (sz == 0 && !push_ok) m_fifo = MODE;
    endtask

    // One clock: update model, take edge, compare every observable output.
    task automatic cyc();
        int n;
        model_update();
        @(posedge CLK);
        #1;
        n = mq.size();
        chk("count",    32'(COUNT),        32'(n));
        chk("data_rd",  32'(DATA_RD),      32'(m_rd));
        chk("rd_valid", 32'(RD_VALID),     32'(m_valid));
        chk("full",     32'(stack_full),   32'(n == 4));
        chk("empty",    32'(stack_empty),  32'(n == 0));
        chk("afull",    32'(ALMOST_FULL),  32'(n >= 3));
        chk("aempty",   32'(ALMOST_EMPTY), 32'(n <= 1));
        chk("ovf",      32'(OVERFLOW),     32'(m_ovf));
        chk("unf",      32'(UNDERFLOW),    32'(m_unf));
        @(negedge CLK);
    endtask

    task automatic op(input logic w, input logic r, input logic [7:0] d);
        RST = 1'b0; FLUSH = 1'b0; CLR_ERR = 1'b0;
        W = w; R = r; DATA_WR = d;
        cyc();
    endtask

    task automatic push(input logic [7:0] d); op(1'b1, 1'b0, d); endtask
    task automatic pop(); op(1'b0, 1'b1, 8'h00); endtask
    task automatic idle(); op(1'b0, 1'b0, 8'h00); endtask

    initial begin
        logic [7:0] exp_seq [4];
        @(negedge CLK);
        RST = 1'b1;
        cyc();
        chk("rst_count", 32'(COUNT), 32'd0);
        chk("rst_data",  32'(DATA_RD), 32'd0);

        // LIFO fill, overflow, drain
        MODE = 1'b0;
        idle();
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        chk("t1_full", 32'(stack_full), 32'd1);
        push(8'h55);
        chk("t1_ovf", 32'(OVERFLOW), 32'd1);
        exp_seq[0] = 8'h44; exp_seq[1] = 8'h33; exp_seq[2] = 8'h22; exp_seq[3] = 8'h11;
        for (int i = 0; i < 4; i++) begin
            pop();
            chk("t1_pop", 32'(DATA_RD), 32'(exp_seq[i]));
        end
        chk("t1_empty", 32'(stack_empty), 32'd1);

        // FIFO with pointer wrap
        CLR_ERR = 1'b1; W = 1'b0; R = 1'b0; cyc();
        MODE = 1'b1;
        idle();
        for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
        pop(); pop();
        push(8'hA4); push(8'hA5);
        for (int i = 0; i < 4; i++) begin
            pop();
            chk("t2_pop", 32'(DATA_RD), 32'(8'hA2 + 8'(i)));
        end
        chk("t2_count", 32'(COUNT), 32'd0);

        // Same-cycle push+pop in LIFO, then FIFO full
        MODE = 1'b0;
        idle();
        push(8'h01); push(8'h02);
        op(1'b1, 1'b1, 8'h09);
        chk("t3_rd", 32'(DATA_RD), 32'h02);
        chk("t3_cnt", 32'(COUNT), 32'd2);
        pop();
        chk("t3_next", 32'(DATA_RD), 32'h09);
        pop();
        MODE = 1'b1;
        idle();
        for (int i = 0; i < 4; i++) push(8'hC0 + 8'(i));
        op(1'b1, 1'b1, 8'hC4);
        chk("t3_fcnt", 32'(COUNT), 32'd4);
        chk("t3_fovf", 32'(OVERFLOW), 32'd0);
        chk("t3_fhead", 32'(DATA_RD), 32'hC0);
        RST = 1'b0; W = 1'b0; R = 1'b0; FLUSH = 1'b1; cyc();

        // Empty push+pop: pop rejected, push lands
        op(1'b1, 1'b1, 8'h7E);
        chk("t4_unf", 32'(UNDERFLOW), 32'd1);
        chk("t4_val", 32'(RD_VALID), 32'd0);
        chk("t4_cnt", 32'(COUNT), 32'd1);
        pop();
        chk("t4_pop", 32'(DATA_RD), 32'h7E);
        W = 1'b0; R = 1'b0; CLR_ERR = 1'b1; cyc();
        chk("t4_clr", 32'(UNDERFLOW), 32'd0);

        // Flags, flush with push, mode change ignored while occupied
        MODE = 1'b0;
        idle();
        push(8'h31); push(8'h32); push(8'h33);
        chk("t5_af", 32'(ALMOST_FULL), 32'd1);
        chk("t5_ae", 32'(ALMOST_EMPTY), 32'd0);
        W = 1'b1; R = 1'b0; FLUSH = 1'b1; DATA_WR = 8'h99; cyc();
        chk("t5_fcnt", 32'(COUNT), 32'd0);
        chk("t5_fovf", 32'(OVERFLOW), 32'd0);
        push(8'h41); push(8'h42);
        MODE = 1'b1;
        pop();
        chk("t5_order", 32'(DATA_RD), 32'h42);
        pop();

        // Reset mid-operation
        MODE = 1'b0;
        idle();
        push(8'h51); push(8'h52); push(8'h53);
        W = 1'b0; R = 1'b0; RST = 1'b1; cyc();
        chk("t6_cnt", 32'(COUNT), 32'd0);
        chk("t6_data", 32'(DATA_RD), 32'd0);
        pop();
        chk("t6_unf", 32'(UNDERFLOW), 32'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            RST     = ($urandom_range(0, 199) == 0);
            FLUSH   = ($urandom_range(0, 39) == 0);
            CLR_ERR = ($urandom_range(0, 15) == 0);
            MODE    = 1'($urandom_range(0, 1));
            W       = ($urandom_range(0, 99) < 55);
            R       = ($urandom_range(0, 99) < 45);
            DATA_WR = 8'($urandom);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
